// File: rtl/mult_pkg.sv
// Shared widths and defaults for the 4x4 approximate carry-save array multiplier.
package mult_pkg;
  localparam int N_BITS          = 4;
  localparam int P_BITS          = 8;
  localparam int APPROX_COLS_DEF = 3;
endpackage

// File: rtl/csam_full_adder.sv
// One-bit full adder cell of the carry-save array; half adders tie cin low.
module csam_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/approx_mult4x4_csam.sv
// Registered 4x4 unsigned approximate multiplier: OR-compressed low columns,
// carry-save array plus ripple adder for the remaining columns.
module approx_mult4x4_csam
  import mult_pkg::*;
#(
  parameter int APPROX_COLS = APPROX_COLS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  output logic              out_valid,
  output logic [P_BITS-1:0] P
);
  logic [N_BITS-1:0][N_BITS-1:0] pp;      // pp[i][j] = A[j] & B[i], approximated columns zeroed
  logic [P_BITS-1:0]             or_col;
  logic [P_BITS-1:0]             sum_exact;
  logic [P_BITS-1:0]             p_d, p_q;
  logic                          vld_q;
  logic                          s [N_BITS][N_BITS];
  logic                          c [N_BITS][N_BITS];
  logic [2:0]                    rc;

  always_comb begin
    pp     = '0;
    or_col = '0;
    for (int i = 0; i < N_BITS; i++) begin
      for (int j = 0; j < N_BITS; j++) begin
        if (i + j < APPROX_COLS) or_col[i+j] = or_col[i+j] | (A[j] & B[i]);
        else                     pp[i][j]    = A[j] & B[i];
      end
    end
  end

  genvar r, j;
  for (j = 0; j < N_BITS; j++) begin : g_row0
    assign s[0][j] = pp[0][j];
    assign c[0][j] = 1'b0;
  end

  // Row r cell j has weight r+j: adds pp, the shifted sum and the carry of the row above.
  for (r = 1; r < N_BITS; r++) begin : g_row
    for (j = 0; j < N_BITS; j++) begin : g_col
      logic b_in;
      if (j < N_BITS - 1) begin : g_sum
        assign b_in = s[r-1][j+1];
      end else begin : g_top
        assign b_in = 1'b0;
      end
      csam_full_adder u_fa (
        .a   (pp[r][j]),
        .b   (b_in),
        .cin (c[r-1][j]),
        .sum (s[r][j]),
        .cout(c[r][j])
      );
    end
  end

  for (j = 0; j < N_BITS - 1; j++) begin : g_rip
    logic cin_r;
    if (j == 0) begin : g_first
      assign cin_r = 1'b0;
    end else begin : g_next
      assign cin_r = rc[j-1];
    end
    csam_full_adder u_fa (
      .a   (s[N_BITS-1][j+1]),
      .b   (c[N_BITS-1][j]),
      .cin (cin_r),
      .sum (sum_exact[N_BITS+j]),
      .cout(rc[j])
    );
  end

  // Product never exceeds 225, so bit 7 cannot carry out: a half-adder sum suffices.
  assign sum_exact[P_BITS-1] = c[N_BITS-1][N_BITS-1] ^ rc[2];
  assign sum_exact[0] = s[0][0];
  for (r = 1; r < N_BITS; r++) begin : g_low
    assign sum_exact[r] = s[r][0];
  end

  // Exact part has zeros below APPROX_COLS, so OR merges the compressed columns.
  assign p_d = sum_exact | or_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) p_q <= p_d;
    end
  end

  assign P         = p_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_approx_mult4x4_csam.sv
// Self-checking bench: directed and random requests against a column-sum reference model.
module tb_approx_mult4x4_csam;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A, B;
  logic       out_valid, out_valid0;
  logic [7:0] P, P0;
  int         n_pass = 0;
  int         n_total = 0;

  approx_mult4x4_csam #(.APPROX_COLS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid), .P(P)
  );
  approx_mult4x4_csam #(.APPROX_COLS(0)) dut_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid0), .P(P0)
  );

  always #5 clk = ~clk;

  function automatic int model(input int a, input int b, input int ac);
    int acc = 0;
    int orb [7];
    for (int k = 0; k < 7; k++) orb[k] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int bit_ij = ((a >> j) & 1) * ((b >> i) & 1);
        if (i + j >= ac) acc += bit_ij << (i + j);
        else if (bit_ij != 0) orb[i+j] = 1;
      end
    for (int k = 0; k < 7; k++) acc += orb[k] << k;
    return acc;
  endfunction

  task automatic req(input int a, input int b);
    A = 4'(a); B = 4'(b); in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; A = 4'd15; B = 4'd15;
    #1;
    n_total++;
    if ({out_valid, P} !== 9'd0) $display("FAIL reset_immediate: got v=%0b P=%0d expected v=0 P=0", out_valid, P);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_total++;
      if ({out_valid, P} !== 9'd0) $display("FAIL reset_hold: got v=%0b P=%0d expected v=0 P=0", out_valid, P);
      else n_pass++;
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    int ta [5] = '{0, 1, 3, 10, 5};
    int tb [5] = '{0, 1, 5, 6, 9};
    int te [5] = '{0, 1, 15, 60, 45};
    for (int k = 0; k < 5; k++) begin
      req(ta[k], tb[k]);
      n_total++;
      if (P !== 8'(te[k]) || out_valid !== 1'b1)
        $display("FAIL exact_%0dx%0d: got P=%0d v=%0b expected P=%0d v=1", ta[k], tb[k], P, out_valid, te[k]);
      else n_pass++;
    end
  endtask

  task automatic test_approx();
    int ta [3] = '{15, 7, 3};
    int te [3] = '{215, 39, 7};
    for (int k = 0; k < 3; k++) begin
      req(ta[k], ta[k]);
      n_total++;
      if (P !== 8'(te[k]) || out_valid !== 1'b1)
        $display("FAIL approx_%0dx%0d: got P=%0d v=%0b expected P=%0d v=1", ta[k], ta[k], P, out_valid, te[k]);
      else n_pass++;
    end
  endtask

  task automatic test_valid_gap();
    req(10, 6);
    chk("gap_first", P, 60);
    in_valid = 1'b0; A = 4'bxxxx; B = 4'bxxxx;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0 || P !== 8'd60)
        $display("FAIL gap_hold: got P=%0d v=%0b expected P=60 v=0", P, out_valid);
      else n_pass++;
    end
    req(3, 5);
    chk("gap_resume", P, 15);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      int a = int'($urandom_range(0, 15));
      int b = int'($urandom_range(0, 15));
      req(a, b);
      n_total++;
      if (P !== 8'(model(a, b, 3)) || out_valid !== 1'b1)
        $display("FAIL b2b_%0dx%0d: got P=%0d v=%0b expected P=%0d v=1", a, b, P, out_valid, model(a, b, 3));
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        req(a, b);
        chk($sformatf("sweep_%0dx%0d", a, b), P, model(a, b, 3));
        n_total++;
        if (int'(P) > a * b) $display("FAIL sweep_bound_%0dx%0d: got %0d expected <= %0d", a, b, P, a * b);
        else n_pass++;
        chk($sformatf("sweep_exact_%0dx%0d", a, b), P0, a * b);
      end
  endtask

  task automatic test_async_reset();
    req(15, 15);
    chk("async_pre", P, 215);
    req(7, 7);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, P} !== 9'd0) $display("FAIL async_clear: got v=%0b P=%0d expected v=0 P=0", out_valid, P);
    else n_pass++;
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("async_idle_v", out_valid, 0);
    req(5, 9);
    chk("async_resume", P, 45);
    chk("async_resume_v", out_valid, 1);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_valid_gap();
    test_back_to_back();
    test_sweep();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
